// File: rtl/timer_if.sv
// timer_if: bridge-side device bus of one timer window (address, write data, byte enables, read data, irq)
interface timer_if;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  byteen;
    logic [31:0] rdat;
    logic        irq;
    modport master (output addr, wdat, byteen, input rdat, irq);
    modport slave  (input addr, wdat, byteen, output rdat, irq);
endinterface

// File: rtl/timer.sv
// timer: memory-mapped countdown timer with CTRL/PRESET/COUNT registers,
// one-shot or auto-reload interrupt generation
module timer (
    input  logic    clk,
    input  logic    reset,
    timer_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CNT  = 2'd2;
    localparam logic [1:0] INT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic [1:0]  sel;
    logic        wr;

    assign sel = bus.addr[3:2];
    assign wr  = |bus.byteen;

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
        if (wr) begin
            // register writes freeze the FSM for the cycle
            if (sel == 2'd0) begin
                if (bus.byteen[0]) ctrl_d = bus.wdat[3:0];
                flag_d = 1'b0;
            end
            if (sel == 2'd1) begin
                for (int i = 0; i < 4; i++)
                    if (bus.byteen[i]) preset_d[8*i +: 8] = bus.wdat[8*i +: 8];
                flag_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: state_d = ctrl_q[0] ? LOAD : IDLE;
                LOAD: begin
                    count_d = preset_q;
                    state_d = CNT;
                end
                CNT: begin
                    if (!ctrl_q[0]) state_d = IDLE;
                    else if (count_q > 32'd1) count_d = count_q - 32'd1;
                    else begin
                        count_d = '0;
                        flag_d  = 1'b1;
                        state_d = INT;
                    end
                end
                default: begin
                    if (ctrl_q[2:1] == 2'b01) flag_d = 1'b0;
                    else ctrl_d[0] = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.rdat = sel == 2'd0 ? {28'd0, ctrl_q} :
                      sel == 2'd1 ? preset_q :
                      sel == 2'd2 ? count_q : 32'd0;
    assign bus.irq  = flag_q & ctrl_q[3];
endmodule

// File: tb/tb_timer.sv
// tb_timer: table-driven register checks plus hand-written timing sequences for timer
module tb_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    timer_if bus ();

    timer u_dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        ir;
        bit          use_rd;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vt[8];
    int n_chk = 0;
    int n_pass = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.addr = a;
        bus.wdat = d;
        bus.byteen = be;
        @(posedge clk);
        #1;
        bus.byteen = 4'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] rd,
                       input logic ir, input bit use_rd);
        exp_t e;
        sb.push_back('{name, rd, ir, use_rd});
        bus.addr = a;
        bus.byteen = 4'd0;
        #1;
        e = sb.pop_front();
        if (e.use_rd) begin
            n_chk++;
            if (bus.rdat === e.rd) n_pass++;
            else $display("FAIL %s rdat: got %h expected %h", e.name, bus.rdat, e.rd);
        end
        n_chk++;
        if (bus.irq === e.ir) n_pass++;
        else $display("FAIL %s irq: got %b expected %b", e.name, bus.irq, e.ir);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.addr = '0;
        bus.wdat = '0;
        bus.byteen = '0;
        vt[0] = '{32'h4, 32'h0000_0000, 4'hF, 32'h4, 32'h0000_0000};
        vt[1] = '{32'h4, 32'hAABB_CCDD, 4'h2, 32'h4, 32'h0000_CC00};
        vt[2] = '{32'h4, 32'h1122_3344, 4'hC, 32'h4, 32'h1122_CC00};
        vt[3] = '{32'h4, 32'h5566_7788, 4'h1, 32'h4, 32'h1122_CC88};
        vt[4] = '{32'h8, 32'hFFFF_FFFF, 4'hF, 32'h8, 32'h0000_0000};
        vt[5] = '{32'hC, 32'hFFFF_FFFF, 4'hF, 32'hC, 32'h0000_0000};
        vt[6] = '{32'h0, 32'hFFFF_FFF6, 4'hE, 32'h0, 32'h0000_0000};
        vt[7] = '{32'h0, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0000_000F};
        do_reset();

        // reset mid-count
        wr(32'h4, 32'd10, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        tick(5);
        chk("rst_pre_count", 32'h8, 32'd7, 1'b0, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_ctrl", 32'h0, 32'd0, 1'b0, 1);
        chk("rst_preset", 32'h4, 32'd0, 1'b0, 1);
        chk("rst_count", 32'h8, 32'd0, 1'b0, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        tick(3);
        chk("rel_ctrl", 32'h0, 32'd0, 1'b0, 1);
        chk("rel_preset", 32'h4, 32'd0, 1'b0, 1);
        chk("rel_count", 32'h8, 32'd0, 1'b0, 1);

        // byte lanes and decode
        for (int i = 0; i < 8; i++) begin
            wr(vt[i].a, vt[i].d, vt[i].be);
            chk($sformatf("vec%0d", i), vt[i].ra, vt[i].exp, 1'b0, 1);
        end
        do_reset();

        // one-shot
        wr(32'h4, 32'd5, 4'hF);
        wr(32'h0, 32'h9, 4'hF);
        tick(2);
        chk("os_e2", 32'h8, 32'd5, 1'b0, 1);
        tick(4);
        chk("os_e6", 32'h8, 32'd1, 1'b0, 1);
        tick(1);
        chk("os_e7", 32'h8, 32'd0, 1'b1, 1);
        tick(1);
        chk("os_e8_ctrl", 32'h0, 32'h8, 1'b1, 1);
        for (int k = 0; k < 18; k++) begin
            tick(1);
            chk("os_hold", 32'h8, 32'd0, 1'b1, 0);
        end
        wr(32'h0, 32'h8, 4'hF);
        chk("os_clear", 32'h0, 32'h8, 1'b0, 1);
        do_reset();

        // auto-reload
        wr(32'h4, 32'd3, 4'hF);
        wr(32'h0, 32'hB, 4'hF);
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            chk($sformatf("ar_e%0d", k), 32'h0, 32'h0, (k >= 5 && (k - 5) % 6 == 0), 0);
        end
        wr(32'h0, 32'h0, 4'hF);
        do_reset();

        // masked interrupt
        wr(32'h4, 32'd2, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk("mask_irq", 32'h8, 32'd0, 1'b0, 0);
        end
        chk("mask_count", 32'h8, 32'd0, 1'b0, 1);
        chk("mask_ctrl", 32'h0, 32'h0, 1'b0, 1);
        do_reset();

        // disable mid-count, count write ignored, re-enable reloads
        wr(32'h4, 32'd10, 4'hF);
        wr(32'h0, 32'h9, 4'hF);
        tick(6);
        chk("dis_at6", 32'h8, 32'd6, 1'b0, 1);
        wr(32'h0, 32'h8, 4'hF);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("dis_hold", 32'h8, 32'd6, 1'b0, 1);
        end
        wr(32'h8, 32'hFFFF_FFFF, 4'hF);
        chk("count_ro", 32'h8, 32'd6, 1'b0, 1);
        wr(32'h0, 32'h9, 4'hF);
        chk("re_f0", 32'h8, 32'd6, 1'b0, 1);
        tick(1);
        chk("re_f1", 32'h8, 32'd6, 1'b0, 1);
        tick(1);
        chk("re_f2", 32'h8, 32'd10, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/timer.md
# timer

Memory-mapped countdown timer on the bridge's device side, one instance per timer window (Timer0 at 0x7F00–0x7F0B, Timer1 at 0x7F10–0x7F1B). It consumes the bridge's shared address/write-data bus and its per-device byte enable, and returns read data plus an interrupt request toward the CP0 interrupt inputs. Three word registers: CTRL, PRESET and COUNT. A 4-state FSM counts COUNT down from PRESET and raises an interrupt in one-shot (mode 0) or auto-reload (mode 1) fashion.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- addr  in  32  DEVaddr from bridge; only addr[3:2] decoded
- wdat  in  32  DEVwdat from bridge
- byteen  in  4  per-device byte enable from bridge; nonzero = write cycle
- rdat  out  32  combinational read data
- irq  out  1  interrupt request = irq_flag & CTRL.IM

## Operation
- Register map by addr[3:2]: 0 CTRL (R/W), 1 PRESET (R/W), 2 COUNT (read-only, writes ignored), 3 reads 0, writes ignored.
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), [3] IM. CTRL[31:4] always read 0; writes to them are dropped.
- Writes: byteen[i] writes wdat[8i+7:8i] of the selected register. This gives byte, halfword and word stores.
- Write cycle (byteen != 0): only the register update happens. FSM state and COUNT hold for that cycle. A write to CTRL or PRESET clears irq_flag.
- rdat = selected register, zero-extended as above. This is independent of byteen.
- FSM, evaluated only in non-write cycles:
  - IDLE: EN=1 → LOAD; else stay.
  - LOAD: COUNT ← PRESET → CNT. This transition is unconditional.
  - CNT: EN=0 → IDLE, COUNT holds. Else if COUNT > 1, COUNT ← COUNT−1. Else (COUNT ≤ 1): COUNT ← 0, irq_flag ← 1, → INT.
  - INT: MODE=01: irq_flag ← 0. Otherwise: CTRL.EN ← 0 and irq_flag holds. Then → IDLE.
- Mode 0: irq_flag stays set until software writes CTRL or PRESET, or reset.
- Mode 1: the timer reloads PRESET and repeats indefinitely.
- COUNT is 32-bit unsigned. It never wraps, because 0 and 1 both terminate the count.

## Timing
- Reset (async, immediate): CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0. Consequently irq=0 and rdat=0 for any address.
- Let E0 be the edge that writes EN=1 while the FSM is in IDLE, with preset P. Then:
  - E1: → LOAD
  - E2: COUNT=P
  - irq_flag rises at edge E0+max(P,1)+2
- Mode 0: irq stays high (if IM=1) until a CTRL/PRESET write. EN reads 0 one edge after irq rises.
- Mode 1: irq is high for exactly one cycle. The period is max(P,1)+3 cycles.
- Interrupt masking: IM=0 masks irq only; irq_flag still sets. Setting IM later does not raise irq, because that CTRL write clears irq_flag.
- Disable mid-count: the EN=0 write edge holds the FSM. The next edge goes CNT → IDLE with COUNT frozen.
- Re-enable after a disable restarts from LOAD, i.e. it reloads PRESET.
- A write landing on the INT cycle delays INT processing by one cycle. INT then still executes, so in mode 0 a just-written EN=1 is cleared.
- PRESET written during CNT has no effect until the next LOAD.
- Reset asserted mid-count aborts immediately to the reset values.

## Test plan
- Reset: assert reset mid-count with COUNT=7 → irq=0 and reads of 0x0/0x4/0x8 return 0 while reset is high and after release.
- One-shot: PRESET=5, then CTRL=0x9 at edge E0 → COUNT reads 5 after E2, 1 after E6, 0 after E7, with irq high from E7. CTRL reads 0x8 after E8. irq stays high 20 cycles, then drops on the edge that writes CTRL=0x8.
- Auto-reload: PRESET=3, CTRL=0xB → irq pulses 1 cycle wide, first at E0+5, then every 6 cycles, for 4 pulses.
- Mask: PRESET=2, CTRL=0x1 → irq stays 0 throughout. COUNT reaches 0 and CTRL reads 0x0.
- Disable mid-count: PRESET=10, CTRL=0x9; write CTRL=0x8 when COUNT=6 → COUNT stays 6 for 10 cycles and irq=0. Rewrite CTRL=0x9 → COUNT reloads to 10 two edges later.
- Byte lanes / decode: write wdat=0xAABBCCDD to 0x4 with byteen=0b0010 after PRESET=0 → PRESET reads 0x0000CC00. Write 0xFFFFFFFF to 0x8 with byteen=0xF → COUNT is unchanged. Read 0xC → 0. Write CTRL=0xFFFFFFFF → CTRL reads 0xF.
